ascon_perm_ctrl: RTL and testbench
==================================

Name: ascon_perm_ctrl

Overview:
- Moore controller that sequences the single-round ASCON permutation datapath (constant addition, substitution, linear diffusion, state register).
- Runs p^12 or p^8 on request, drives the round-constant index and the state-register enable/mux controls, and signals completion with a valid/ack handshake.
- Sits between the top-level ASCON mode FSM and the permutation datapath.

Parameters:
- CNT_W, 4, width of the round index; must hold 0..11.

Ports:
- clock_i  in  1  system clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request a permutation; accepted only when ready_o=1.
- mode_i  in  1  sampled with start_i; 0 = p^12 (a rounds), 1 = p^8 (b rounds).
- ack_i  in  1  consumer acknowledges the result while valid_o=1.
- ready_o  out  1  controller idle, can accept start_i.
- round_o  out  CNT_W  index into round_constant for the current round.
- sel_init_o  out  1  datapath round input mux: 1 = external state, 0 = state-register feedback.
- en_state_o  out  1  state-register write enable.
- valid_o  out  1  permutation result stable in state register.

Behaviour:
- Clock and reset: single clock, clock_i; reset_i is asynchronous and active-high.
- Reset values: FSM state IDLE, round_o=0, ready_o=1, sel_init_o=0, en_state_o=0, valid_o=0.
- FSM states are IDLE, FIRST, RUN and DONE.
- IDLE
  - ready_o=1.
  - On start_i=1 go to FIRST and load the round counter with 0 for p^12 or 4 for p^8 (p^8 uses the last 8 constants, indices 4..11).
  - mode_i is ignored outside the acceptance cycle.
- FIRST (one cycle)
  - sel_init_o=1, en_state_o=1, round_o = start index.
  - Next: RUN; counter increments.
- RUN
  - sel_init_o=0, en_state_o=1, one round per cycle; counter increments each cycle.
  - When round_o=11 this cycle, next state is DONE and the counter holds at 11.
- DONE
  - valid_o=1, en_state_o=0, ready_o=0.
  - Stay until ack_i=1, then go to IDLE and reset the counter to 0.
  - ack_i in the first DONE cycle is legal: valid_o lasts one cycle.
- Latency: start accepted at edge N; p^12 gives valid_o=1 from cycle N+13, p^8 from cycle N+9 (12 and 8 enabled round cycles respectively).
- Outputs are Moore (a function of FSM state and counter only); no combinational path from any input to any output.
- start_i while busy (FIRST/RUN/DONE) is ignored and not queued.
- ack_i outside DONE is ignored.
- Counter never wraps past 11; a value above 11 is unreachable.
- reset_i asserted mid-permutation forces the reset values immediately; the state register contents are don't-care.

Optional Feature:
- Macro: ASCON_ABORT_EN.
- Defined:
  - Adds port abort_i (in, 1).
  - abort_i=1 in FIRST, RUN or DONE forces IDLE at the next edge: counter=0, en_state_o=0, valid_o=0.
  - abort_i takes priority over ack_i.
  - In IDLE, abort_i is ignored and start_i is still accepted.
- Undefined: no abort_i port; behaviour exactly as above.

Decomposition:
- ascon_pack holds the following:
  - existing type_state, round_constant, a, b;
  - new typedef enum type_perm_fsm {IDLE, FIRST, RUN, DONE};
  - new constant for the p^8 start index, equal to 12 - b.
- Natural sub-module: ascon_round_counter, a CNT_W loadable up-counter with inputs load, load_val, en and output count.

Test Plan:
- Reset: assert reset_i mid-cycle with no clock edge -> all outputs at reset values immediately; ready_o=1.
- p^12: start_i=1, mode_i=0 at edge 0 -> FIRST with round_o=0 and sel_init_o=1; round_o steps 1..11 with en_state_o=1; valid_o=1 at cycle 13; ack_i=1 -> ready_o=1 on the next cycle.
- p^8: start_i=1, mode_i=1 -> round_o sequence 4,5,...,11, en_state_o=1 for exactly 8 cycles; valid_o at cycle 9.
- Protocol: start_i held high during RUN and DONE -> no restart; hold ack_i=0 for 5 cycles in DONE -> valid_o stays 1 and en_state_o stays 0; ack_i pulsed in RUN -> ignored.
- Back-to-back: ack_i in the DONE cycle and start_i in the following IDLE cycle -> second permutation starts with round_o at 0 or 4, no lost cycle.
- Reset mid-RUN at round_o=6 -> immediate IDLE values. With ASCON_ABORT_EN: abort_i at round_o=7 -> IDLE at the next edge, valid_o never asserted.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared ASCON types and constants for the permutation controller and datapath.
// The optional abort input of ascon_perm_ctrl is enabled with ASCON_ABORT_EN.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int unsigned a = 12;
    localparam int unsigned b = 8;

    // p^8 runs on the last b constants of the table, so it starts at index a - b
    localparam int unsigned P8_START   = a - b;
    localparam int unsigned ROUND_LAST = a - 1;

    localparam logic [7:0] round_constant [0:11] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } type_perm_fsm;

    function automatic int unsigned start_index(input logic mode);
        if (mode) begin
            return P8_START;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Loadable up-counter holding the round-constant index of the permutation.
// Load takes priority over increment; with neither asserted the count holds.
module ascon_round_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count selection: load, increment or hold
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Moore controller sequencing p^12 / p^8 on the single-round ASCON datapath.
// Define ASCON_ABORT_EN to add the abort_i input that returns the FSM to IDLE.
module ascon_perm_ctrl
    import ascon_pack::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_i,
`ifdef ASCON_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             ack_i,
    output logic             ready_o,
    output logic [CNT_W-1:0] round_o,
    output logic             sel_init_o,
    output logic             en_state_o,
    output logic             valid_o
);

    type_perm_fsm     state_q;
    logic             ready_q;
    logic             sel_init_q;
    logic             en_state_q;
    logic             valid_q;

    logic [CNT_W-1:0] round_q;
    logic             last_round;
    logic             abort_s;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;

`ifdef ASCON_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    assign last_round = (round_q == CNT_W'(ROUND_LAST));

    // Round counter control derived from the current state; it never steps past the last round
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_load = 1'b1;
                if (start_i) begin
                    cnt_load_val = CNT_W'(start_index(mode_i));
                end else begin
                    cnt_load_val = '0;
                end
            end
            FIRST: begin
                if (abort_s) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RUN: begin
                if (abort_s) begin
                    cnt_load = 1'b1;
                end else if (!last_round) begin
                    cnt_en = 1'b1;
                end else begin
                    cnt_en = 1'b0;
                end
            end
            DONE: begin
                if (abort_s || ack_i) begin
                    cnt_load = 1'b1;
                end else begin
                    cnt_load = 1'b0;
                end
            end
            default: begin
                cnt_load = 1'b1;
            end
        endcase
    end

    ascon_round_counter #(
        .CNT_W (CNT_W)
    ) u_round_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .count_o    (round_q)
    );

    // Permutation FSM; outputs are registered so they reflect the state being entered
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            sel_init_q <= 1'b0;
            en_state_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q    <= FIRST;
                        ready_q    <= 1'b0;
                        sel_init_q <= 1'b1;
                        en_state_q <= 1'b1;
                        valid_q    <= 1'b0;
                    end else begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end
                end
                FIRST: begin
                    if (abort_s) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end else begin
                        state_q    <= RUN;
                        ready_q    <= 1'b0;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_s) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end else if (last_round) begin
                        state_q    <= DONE;
                        ready_q    <= 1'b0;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b1;
                    end else begin
                        state_q    <= RUN;
                        ready_q    <= 1'b0;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end
                DONE: begin
                    if (abort_s || ack_i) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end else begin
                        state_q    <= DONE;
                        ready_q    <= 1'b0;
                        sel_init_q <= 1'b0;
                        en_state_q <= 1'b0;
                        valid_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ready_q    <= 1'b1;
                    sel_init_q <= 1'b0;
                    en_state_q <= 1'b0;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign round_o    = round_q;
    assign sel_init_o = sel_init_q;
    assign en_state_o = en_state_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed self-checking bench for ascon_perm_ctrl (abort cases need ASCON_ABORT_EN).
module tb_ascon_perm_ctrl;

    logic       clock_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       mode_i;
    logic       ack_i;
`ifdef ASCON_ABORT_EN
    logic       abort_i;
`endif
    logic       ready_o;
    logic [3:0] round_o;
    logic       sel_init_o;
    logic       en_state_o;
    logic       valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_i = ~clock_i;

    ascon_perm_ctrl #(
        .CNT_W (4)
    ) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .mode_i     (mode_i),
`ifdef ASCON_ABORT_EN
        .abort_i    (abort_i),
`endif
        .ack_i      (ack_i),
        .ready_o    (ready_o),
        .round_o    (round_o),
        .sel_init_o (sel_init_o),
        .en_state_o (en_state_o),
        .valid_o    (valid_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".ready"}, 32'(ready_o), 32'd1);
        check_eq({tag, ".valid"}, 32'(valid_o), 32'd0);
        check_eq({tag, ".en"},    32'(en_state_o), 32'd0);
        check_eq({tag, ".sel"},   32'(sel_init_o), 32'd0);
        check_eq({tag, ".round"}, 32'(round_o), 32'd0);
    endtask

    // One permutation from acceptance to acknowledge, checking every cycle
    task automatic run_perm(input logic mode, input int ack_delay,
                            input logic hold_start, input logic pulse_ack_run);
        int first;
        int en_seen;
        first   = mode ? 4 : 0;
        start_i = 1'b1;
        mode_i  = mode;
        tick();
        if (!hold_start) start_i = 1'b0;
        mode_i = ~mode;
        check_eq("first.round", 32'(round_o), 32'(first));
        check_eq("first.sel",   32'(sel_init_o), 32'd1);
        check_eq("first.en",    32'(en_state_o), 32'd1);
        check_eq("first.ready", 32'(ready_o), 32'd0);
        check_eq("first.valid", 32'(valid_o), 32'd0);
        en_seen = 32'(en_state_o);
        for (int r = first + 1; r <= 11; r++) begin
            if (pulse_ack_run && r == 7) ack_i = 1'b1;
            tick();
            ack_i = 1'b0;
            check_eq("run.round", 32'(round_o), 32'(r));
            check_eq("run.en",    32'(en_state_o), 32'd1);
            check_eq("run.sel",   32'(sel_init_o), 32'd0);
            check_eq("run.valid", 32'(valid_o), 32'd0);
            check_eq("run.ready", 32'(ready_o), 32'd0);
            en_seen += 32'(en_state_o);
        end
        tick();
        check_eq("done.valid",  32'(valid_o), 32'd1);
        check_eq("done.en",     32'(en_state_o), 32'd0);
        check_eq("done.ready",  32'(ready_o), 32'd0);
        check_eq("done.round",  32'(round_o), 32'd11);
        check_eq("done.rounds", 32'(en_seen), mode ? 32'd8 : 32'd12);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check_eq("hold.valid", 32'(valid_o), 32'd1);
            check_eq("hold.en",    32'(en_state_o), 32'd0);
            check_eq("hold.round", 32'(round_o), 32'd11);
        end
        ack_i = 1'b1;
        tick();
        ack_i   = 1'b0;
        start_i = 1'b0;
        check_idle("ack");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_i = 1'b0;
        start_i = 1'b0;
        mode_i  = 1'b0;
        ack_i   = 1'b0;
`ifdef ASCON_ABORT_EN
        abort_i = 1'b0;
`endif
        #1 reset_i = 1'b1;
        #2;
        check_idle("reset");
        #10 reset_i = 1'b0;
        tick();
        check_idle("post_reset");

        run_perm(1'b0, 0, 1'b0, 1'b0);
        run_perm(1'b1, 0, 1'b0, 1'b0);
        tick();
        check_idle("idle_gap");
        run_perm(1'b0, 5, 1'b1, 1'b1);
        run_perm(1'b1, 2, 1'b1, 1'b0);

        // Reset asserted between edges while in RUN at round 6
        start_i = 1'b1;
        mode_i  = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("mid.round", 32'(round_o), 32'd6);
        #2 reset_i = 1'b1;
        #1;
        check_idle("mid_reset");
        #3 reset_i = 1'b0;
        tick();
        check_idle("mid_release");
        run_perm(1'b1, 1, 1'b0, 1'b0);

`ifdef ASCON_ABORT_EN
        start_i = 1'b1;
        mode_i  = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("abort.round", 32'(round_o), 32'd7);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 14; i++) begin
            tick();
            check_eq("abort.novalid", 32'(valid_o), 32'd0);
        end
        abort_i = 1'b1;
        start_i = 1'b1;
        mode_i  = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        check_eq("abort_idle.sel",   32'(sel_init_o), 32'd1);
        check_eq("abort_idle.round", 32'(round_o), 32'd4);
        for (int i = 0; i < 8; i++) tick();
        check_eq("abort_done.valid", 32'(valid_o), 32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort_done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
